// File: rtl/cp0_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : cp0_write_sched
//  Description : In-order write scheduler for the CP0 register file. Accepts
//                up to two committed CP0 writes per cycle (slot 0 older than
//                slot 1), buffers them in a FIFO, drains one per cycle into
//                the single CP0 write port, and offers a newest-first lookup
//                of buffered writes for CP0 reads.
//  Revision    : 1.0 - initial release
// ============================================================================
module cp0_write_sched #(
   parameter int DEPTH = 4,
   parameter int AW    = 8,
   parameter int DW    = 32
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in0_valid,
   input  logic [AW-1:0]          in0_addr,
   input  logic [DW-1:0]          in0_data,
   input  logic                   in1_valid,
   input  logic [AW-1:0]          in1_addr,
   input  logic [DW-1:0]          in1_data,
   output logic                   in_ready,
   output logic                   out_valid,
   output logic [AW-1:0]          out_addr,
   output logic [DW-1:0]          out_data,
   input  logic                   out_ready,
   input  logic [AW-1:0]          rd_addr,
   output logic                   rd_hit,
   output logic [DW-1:0]          rd_data,
   output logic                   empty,
   output logic [$clog2(DEPTH):0] count
);

   localparam int c_pw = $clog2(DEPTH);
   localparam int c_cw = c_pw + 1;

   logic [c_pw-1:0] wr_ptr_q, wr_ptr_d;
   logic [c_pw-1:0] rd_ptr_q, rd_ptr_d;
   logic [c_cw-1:0] count_q,  count_d;
   logic            valid_q [DEPTH];
   logic            valid_d [DEPTH];
   logic [AW-1:0]   addr_q  [DEPTH];
   logic [AW-1:0]   addr_d  [DEPTH];
   logic [DW-1:0]   data_q  [DEPTH];
   logic [DW-1:0]   data_d  [DEPTH];

   logic            w_pop;
   logic            w_push0;
   logic            w_push1;
   logic [1:0]      w_n_enq;
   logic [c_pw-1:0] w_slot1_ptr;

   // Acceptance depends only on registered occupancy: no path from CP0 side or in*_valid.
   assign in_ready  = (count_q <= c_cw'(DEPTH - 2));
   assign out_valid = (count_q != '0);
   assign empty     = (count_q == '0);
   assign count     = count_q;
   assign out_addr  = out_valid ? addr_q[rd_ptr_q] : '0;
   assign out_data  = out_valid ? data_q[rd_ptr_q] : '0;

   assign w_pop       = out_valid && out_ready;
   assign w_push0     = in_ready && in0_valid;
   assign w_push1     = in_ready && in1_valid;
   assign w_n_enq     = {1'b0, w_push0} + {1'b0, w_push1};
   // Slot 1 lands behind slot 0 when both are present, otherwise at the tail.
   assign w_slot1_ptr = w_push0 ? (wr_ptr_q + c_pw'(1)) : wr_ptr_q;

   // Next-state: pop the head, append accepted writes in slot order, update pointers/occupancy.
   always_comb begin
      wr_ptr_d = wr_ptr_q + c_pw'(w_n_enq);
      rd_ptr_d = rd_ptr_q + c_pw'(w_pop);
      count_d  = count_q + c_cw'(w_n_enq) - c_cw'(w_pop);
      for (int i = 0; i < DEPTH; i++) begin
         valid_d[i] = valid_q[i];
         addr_d[i]  = addr_q[i];
         data_d[i]  = data_q[i];
      end
      if (w_pop) begin
         valid_d[rd_ptr_q] = 1'b0;
      end
      if (w_push0) begin
         valid_d[wr_ptr_q] = 1'b1;
         addr_d[wr_ptr_q]  = in0_addr;
         data_d[wr_ptr_q]  = in0_data;
      end
      if (w_push1) begin
         valid_d[w_slot1_ptr] = 1'b1;
         addr_d[w_slot1_ptr]  = in1_addr;
         data_d[w_slot1_ptr]  = in1_data;
      end
   end

   // State registers; reset discards every buffered write immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= 1'b0;
            addr_q[i]  <= '0;
            data_q[i]  <= '0;
         end
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         for (int i = 0; i < DEPTH; i++) begin
            valid_q[i] <= valid_d[i];
            addr_q[i]  <= addr_d[i];
            data_q[i]  <= data_d[i];
         end
      end
   end

   // Lookup: scan oldest to newest so the last (newest) match wins.
   always_comb begin
      logic [c_pw-1:0] v_idx;
      rd_hit  = 1'b0;
      rd_data = '0;
      v_idx   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         v_idx = rd_ptr_q + c_pw'(i);
         if ((c_cw'(i) < count_q) && valid_q[v_idx] && (addr_q[v_idx] == rd_addr)) begin
            rd_hit  = 1'b1;
            rd_data = data_q[v_idx];
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_cp0_write_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cp0_write_sched
//  Description : Self-checking bench for cp0_write_sched: vector table,
//                scoreboard of retired writes, and hand-written corner cases.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_cp0_write_sched;

   localparam int DEPTH = 4;
   localparam int AW    = 8;
   localparam int DW    = 32;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          in0_valid = 1'b0, in1_valid = 1'b0;
   logic [AW-1:0] in0_addr = '0, in1_addr = '0;
   logic [DW-1:0] in0_data = '0, in1_data = '0;
   logic          in_ready, out_valid, out_ready = 1'b0;
   logic [AW-1:0] out_addr, rd_addr = '0;
   logic [DW-1:0] out_data, rd_data;
   logic          rd_hit, empty;
   logic [2:0]    count;

   int checks = 0;
   int errors = 0;
   int m_count = 0;

   typedef struct packed {
      logic [AW-1:0] a;
      logic [DW-1:0] d;
   } ent_t;
   ent_t sb[$];

   typedef struct {
      logic          v0;
      logic [AW-1:0] a0;
      logic [DW-1:0] d0;
      logic          v1;
      logic [AW-1:0] a1;
      logic [DW-1:0] d1;
      logic          ordy;
      logic [AW-1:0] rda;
      int            ecnt;
      logic          erdy;
      logic          ehit;
      logic [DW-1:0] erdd;
   } vec_t;

   vec_t tbl[15];

   cp0_write_sched #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
      .clk(clk), .reset(reset),
      .in0_valid(in0_valid), .in0_addr(in0_addr), .in0_data(in0_data),
      .in1_valid(in1_valid), .in1_addr(in1_addr), .in1_data(in1_data),
      .in_ready(in_ready),
      .out_valid(out_valid), .out_addr(out_addr), .out_data(out_data),
      .out_ready(out_ready),
      .rd_addr(rd_addr), .rd_hit(rd_hit), .rd_data(rd_data),
      .empty(empty), .count(count)
   );

   always #5 clk = ~clk;

   // Protocol monitor: upstream must never present writes while in_ready is low.
   always @(posedge clk) begin
      if (!reset && !in_ready && (in0_valid || in1_valid)) begin
         errors++;
         $display("FAIL protocol: in_valid=%b%b while in_ready=0", in1_valid, in0_valid);
      end
   end

   task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic v0, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                               input logic v1, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                               input logic ordy, input logic [AW-1:0] rda, input int ecnt,
                               input logic erdy, input logic ehit, input logic [DW-1:0] erdd);
      vec_t v;
      v.v0 = v0; v.a0 = a0; v.d0 = d0; v.v1 = v1; v.a1 = a1; v.d1 = d1;
      v.ordy = ordy; v.rda = rda; v.ecnt = ecnt; v.erdy = erdy; v.ehit = ehit; v.erdd = erdd;
      return v;
   endfunction

   // One cycle: drive at negedge, score the retiring head, model occupancy, sample after edge.
   task automatic apply(input vec_t v);
      ent_t e;
      bit   acc;
      int   n;
      @(negedge clk);
      in0_valid = v.v0; in0_addr = v.a0; in0_data = v.d0;
      in1_valid = v.v1; in1_addr = v.a1; in1_data = v.d1;
      out_ready = v.ordy; rd_addr = v.rda;
      #1;
      acc = (m_count <= DEPTH - 2);
      chk("in_ready_pre", {31'd0, in_ready}, {31'd0, acc});
      n = 0;
      if (m_count != 0 && v.ordy) begin
         chk("out_valid_pop", {31'd0, out_valid}, 32'd1);
         e = sb.pop_front();
         chk("out_addr", {24'd0, out_addr}, {24'd0, e.a});
         chk("out_data", out_data, e.d);
         n = n - 1;
      end
      if (acc && v.v0) begin sb.push_back({v.a0, v.d0}); n = n + 1; end
      if (acc && v.v1) begin sb.push_back({v.a1, v.d1}); n = n + 1; end
      m_count = m_count + n;
      @(posedge clk);
      #1;
      chk("count_model", {29'd0, count}, m_count);
   endtask

   initial begin
      int   wn;
      int   cyc;
      int   k;
      vec_t v;

      // Inputs, ready, read address  |  expected count, in_ready, rd_hit, rd_data after the edge
      tbl[0]  = mk(1, 8'h60, 32'h0000FF01, 0, 8'h00, 0, 1, 8'h60, 1, 1, 1, 32'h0000FF01);
      tbl[1]  = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h60, 0, 1, 0, 32'h0);
      tbl[2]  = mk(1, 8'h68, 32'hA,        1, 8'h68, 32'hB, 0, 8'h68, 2, 1, 1, 32'hB);
      tbl[3]  = mk(0, 8'h00, 0,            0, 8'h00, 0, 0, 8'h68, 2, 1, 1, 32'hB);
      tbl[4]  = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h68, 1, 1, 1, 32'hB);
      tbl[5]  = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h68, 0, 1, 0, 32'h0);
      tbl[6]  = mk(0, 8'h00, 0,            1, 8'h70, 32'h1234, 0, 8'h70, 1, 1, 1, 32'h1234);
      tbl[7]  = mk(1, 8'h10, 32'h1,        0, 8'h00, 0, 0, 8'h10, 2, 1, 1, 32'h1);
      tbl[8]  = mk(1, 8'h11, 32'h2,        1, 8'h12, 32'h3, 0, 8'h12, 4, 0, 1, 32'h3);
      tbl[9]  = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h70, 3, 0, 0, 32'h0);
      tbl[10] = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h10, 2, 1, 0, 32'h0);
      tbl[11] = mk(1, 8'h14, 32'h5,        1, 8'h15, 32'h6, 1, 8'h15, 3, 0, 1, 32'h6);
      tbl[12] = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h12, 2, 1, 0, 32'h0);
      tbl[13] = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h14, 1, 1, 0, 32'h0);
      tbl[14] = mk(0, 8'h00, 0,            0, 8'h00, 0, 1, 8'h15, 0, 1, 0, 32'h0);

      // Reset state
      repeat (2) @(negedge clk);
      #1;
      chk("rst_count",     {29'd0, count}, 32'd0);
      chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
      chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("rst_out_addr",  {24'd0, out_addr}, 32'd0);
      chk("rst_out_data",  out_data, 32'd0);
      chk("rst_empty",     {31'd0, empty}, 32'd1);
      chk("rst_rd_hit",    {31'd0, rd_hit}, 32'd0);
      chk("rst_rd_data",   rd_data, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      // Table-driven vectors
      for (int i = 0; i < 15; i++) begin
         apply(tbl[i]);
         chk($sformatf("v%0d_count", i),     {29'd0, count}, tbl[i].ecnt);
         chk($sformatf("v%0d_in_ready", i),  {31'd0, in_ready}, {31'd0, tbl[i].erdy});
         chk($sformatf("v%0d_out_valid", i), {31'd0, out_valid}, {31'd0, (tbl[i].ecnt != 0)});
         chk($sformatf("v%0d_empty", i),     {31'd0, empty}, {31'd0, (tbl[i].ecnt == 0)});
         chk($sformatf("v%0d_rd_hit", i),    {31'd0, rd_hit}, {31'd0, tbl[i].ehit});
         chk($sformatf("v%0d_rd_data", i),   rd_data, tbl[i].erdd);
         if (tbl[i].ecnt == 0) begin
            chk($sformatf("v%0d_out_addr_idle", i), {24'd0, out_addr}, 32'd0);
            chk($sformatf("v%0d_out_data_idle", i), out_data, 32'd0);
         end
      end

      // Head being popped still hits in the lookup during its pop cycle
      apply(mk(1, 8'h20, 32'h7, 0, 8'h00, 0, 0, 8'h20, 1, 1, 1, 32'h7));
      apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h20, 1, 1, 1, 32'h7));
      chk("hold_out_addr", {24'd0, out_addr}, 32'h20);
      chk("hold_out_data", out_data, 32'h7);
      @(negedge clk);
      out_ready = 1'b1;
      rd_addr   = 8'h20;
      #1;
      chk("pophit_rd_hit",  {31'd0, rd_hit}, 32'd1);
      chk("pophit_rd_data", rd_data, 32'h7);
      void'(sb.pop_front());
      m_count = 0;
      @(posedge clk);
      #1;
      chk("pophit_after_hit", {31'd0, rd_hit}, 32'd0);
      chk("pophit_after_cnt", {29'd0, count}, 32'd0);

      // Wrap: 12 alternating single/pair writes with random out_ready
      wn  = 0;
      cyc = 0;
      k   = 0;
      while ((wn < 12 || m_count != 0) && cyc < 300) begin
         v = mk(0, 8'h00, 0, 0, 8'h00, 0, 1'($urandom_range(0, 1)), 8'h80, 0, 0, 0, 0);
         if (wn < 12 && m_count <= DEPTH - 2) begin
            if (wn % 2 == 0) begin
               if (wn % 4 == 0) begin
                  v.v0 = 1; v.a0 = 8'(8'h80 + k); v.d0 = 32'(k) + 32'hC000;
               end else begin
                  v.v1 = 1; v.a1 = 8'(8'h80 + k); v.d1 = 32'(k) + 32'hC000;
               end
               k = k + 1;
            end else begin
               v.v0 = 1; v.a0 = 8'(8'h80 + k);     v.d0 = 32'(k) + 32'hC000;
               v.v1 = 1; v.a1 = 8'(8'h80 + k + 1); v.d1 = 32'(k + 1) + 32'hC000;
               k = k + 2;
            end
            wn = wn + 1;
         end
         apply(v);
         checks++;
         if (count > 3'(DEPTH)) begin
            errors++;
            $display("FAIL wrap_count_bound: got %0d expected <= %0d", count, DEPTH);
         end
         cyc++;
      end
      checks++;
      if (cyc >= 300) begin
         errors++;
         $display("FAIL wrap_timeout: got %0d cycles expected < 300", cyc);
      end
      chk("wrap_sb_empty", sb.size(), 32'd0);

      // Reset asserted mid-operation with three buffered writes
      apply(mk(1, 8'h30, 32'h30, 1, 8'h31, 32'h31, 0, 8'h31, 2, 1, 1, 32'h31));
      apply(mk(1, 8'h32, 32'h32, 0, 8'h00, 0, 0, 8'h31, 3, 0, 1, 32'h31));
      chk("pre_rst_count", {29'd0, count}, 32'd3);
      @(negedge clk);
      in0_valid = 0; in1_valid = 0; out_ready = 0;
      reset = 1'b1;
      #1;
      chk("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
      chk("mid_rst_rd_hit",    {31'd0, rd_hit}, 32'd0);
      chk("mid_rst_empty",     {31'd0, empty}, 32'd1);
      chk("mid_rst_in_ready",  {31'd0, in_ready}, 32'd1);
      sb.delete();
      m_count = 0;
      @(negedge clk);
      reset = 1'b0;
      apply(mk(1, 8'h40, 32'h77, 0, 8'h00, 0, 1, 8'h40, 1, 1, 1, 32'h77));
      apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 1, 8'h40, 0, 1, 0, 32'h0));
      chk("post_rst_empty", {31'd0, empty}, 32'd1);
      apply(mk(0, 8'h00, 0, 0, 8'h00, 0, 0, 8'h00, 0, 1, 0, 32'h0));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
